// File: rtl/hilo_div_sched_pkg.sv
// Shared definitions for the HI/LO divider scheduler: FSM encodings and the
// architectural divide-by-zero quotient.
package hilo_div_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_div_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, on a tie the
// pointer picks the winner.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) gnt_o = ptr_i ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/hilo_div_sched.sv
// Schedules the shared iterative divider between the integer pipe (port 0)
// and the coprocessor (port 1); one operation in flight at a time.
module hilo_div_sched
    import hilo_div_sched_pkg::*;
#(
    parameter int WDOG_CYCLES = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_valid_i,
    input  logic [1:0]  req_signed_i,
    input  logic [31:0] req_a0_i,
    input  logic [31:0] req_b0_i,
    input  logic [31:0] req_a1_i,
    input  logic [31:0] req_b1_i,
    output logic [1:0]  req_grant_o,
    input  logic [1:0]  cancel_i,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic        div_busy_i,
    input  logic [31:0] div_q_i,
    input  logic [31:0] div_r_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_q_o,
    output logic [31:0] rsp_r_o,
    output logic        rsp_err_o,
    output logic        sched_busy_o
);

    state_e             state_q;
    logic               rr_ptr_q;
    logic               owner_q;
    logic               signed_q;
    logic [31:0]        a_q, b_q;
    logic [31:0]        q_q, r_q;
    logic               err_q;
    logic [CNT_W-1:0]   wdog_q;

    logic [1:0]  arb_req, arb_gnt;
    logic        winner;
    logic [31:0] win_a, win_b;
    logic        own_cancel, busy_done, wdog_hit;

    // A request flushed in the same cycle never competes for the divider.
    assign arb_req = req_valid_i & ~cancel_i;

    rr_arb2 u_arb (
        .req_i (arb_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    assign req_grant_o = (state_q == S_IDLE) ? arb_gnt : 2'b00;
    assign winner      = arb_gnt[1];
    assign win_a       = winner ? req_a1_i : req_a0_i;
    assign win_b       = winner ? req_b1_i : req_b0_i;
    assign own_cancel  = cancel_i[owner_q];
    // wdog >= 1 skips the cycle right after start, before the divider raises busy.
    assign busy_done   = !div_busy_i && (wdog_q != '0);
    assign wdog_hit    = wdog_q >= CNT_W'(WDOG_CYCLES);

    assign div_start_o  = (state_q == S_LAUNCH);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign sched_busy_o = (state_q != S_IDLE);
    assign div_signed_o = signed_q;
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign rsp_id_o     = owner_q;
    assign rsp_q_o      = q_q;
    assign rsp_r_o      = r_q;
    assign rsp_err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            signed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (|arb_gnt) begin
                    owner_q  <= winner;
                    rr_ptr_q <= ~winner;
                    err_q    <= 1'b0;
                    if (win_b == '0) begin
                        q_q     <= DIV0_QUOTIENT;
                        r_q     <= win_a;
                        state_q <= S_RESP;
                    end else begin
                        a_q      <= win_a;
                        b_q      <= win_b;
                        signed_q <= req_signed_i[winner];
                        state_q  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= own_cancel ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (own_cancel) begin
                        wdog_q  <= wdog_q + CNT_W'(1);
                        state_q <= S_DRAIN;
                    end else if (busy_done) begin
                        q_q     <= div_q_i;
                        r_q     <= div_r_i;
                        state_q <= S_RESP;
                    end else if (wdog_hit) begin
                        err_q   <= 1'b1;
                        q_q     <= '0;
                        r_q     <= '0;
                        state_q <= S_RESP;
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (busy_done || wdog_hit) state_q <= S_IDLE;
                    else                       wdog_q  <= wdog_q + CNT_W'(1);
                end
                S_RESP: if (own_cancel || rsp_ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_sched.sv
// Bench for hilo_div_sched: behavioural 32-cycle divider, grant-time
// scoreboard, result table and hand-written corner sequences.
module tb_hilo_div_sched;

    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0, req_signed = '0, cancel = '0;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  req_grant;
    logic        div_start, div_signed, div_busy;
    logic [31:0] div_a, div_b, div_q, div_r;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, sched_busy;
    logic [31:0] rsp_q, rsp_r;

    always #5 clk = ~clk;

    hilo_div_sched dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_signed_i(req_signed),
        .req_a0_i(req_a0), .req_b0_i(req_b0), .req_a1_i(req_a1), .req_b1_i(req_b1),
        .req_grant_o(req_grant), .cancel_i(cancel),
        .div_start_o(div_start), .div_signed_o(div_signed),
        .div_a_o(div_a), .div_b_o(div_b),
        .div_busy_i(div_busy), .div_q_i(div_q), .div_r_i(div_r),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_q_o(rsp_q), .rsp_r_o(rsp_r), .rsp_err_o(rsp_err),
        .sched_busy_o(sched_busy)
    );

    function automatic logic [63:0] divref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
        return {a / b, a % b};
    endfunction

    // Divider model: busy for DIV_LAT cycles after start, or forever while stuck.
    logic       stuck = 1'b0;
    logic [6:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0; mcnt <= '0; div_q <= '0; div_r <= '0;
        end else if (div_start) begin
            div_busy <= 1'b1;
            mcnt     <= 7'(DIV_LAT);
            {div_q, div_r} <= divref(div_signed, div_a, div_b);
        end else if (!stuck) begin
            if (mcnt > 7'd1) mcnt <= mcnt - 7'd1;
            else begin mcnt <= '0; div_busy <= 1'b0; end
        end
    end

    typedef struct { logic id; logic [31:0] q; logic [31:0] r; logic err; } exp_t;
    typedef struct { logic id; logic sgn; logic [31:0] a, b, q, r; } vec_t;

    exp_t        sb[$];
    vec_t        tbl[6];
    int          n_vec = 0, n_err = 0, cyc_n = 0, n_start = 0, n_rspv = 0;
    int          gnt_cyc = 0, start_cyc = 0, rsp_cyc = 0;
    logic        exp_wdog = 1'b0, got_rsp = 1'b0;
    logic [1:0]  last_gnt = '0;
    logic [31:0] last_q, last_r;
    logic        last_id, last_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // One clock: observe grants/starts/handshakes before the edge, return at the next negedge.
    task automatic cyc();
        exp_t e;
        logic [63:0] qr;
        logic gid;
        #2;
        last_gnt = req_grant;
        if (req_grant != 2'b00) begin
            gid = req_grant[1];
            qr  = divref(req_signed[gid], gid ? req_a1 : req_a0, gid ? req_b1 : req_b0);
            e.id = gid; e.err = exp_wdog;
            e.q = exp_wdog ? 32'd0 : qr[63:32];
            e.r = exp_wdog ? 32'd0 : qr[31:0];
            sb.push_back(e);
            gnt_cyc = cyc_n;
        end
        if (div_start) begin n_start++; start_cyc = cyc_n; end
        if (rsp_valid) n_rspv++;
        if (rsp_valid && rsp_ready && !cancel[rsp_id]) begin
            got_rsp = 1'b1; rsp_cyc = cyc_n;
            last_q = rsp_q; last_r = rsp_r; last_id = rsp_id; last_err = rsp_err;
            if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_q", rsp_q, e.q);
                chk("sb_r", rsp_r, e.r);
                chk("sb_err", 32'(rsp_err), 32'(e.err));
            end
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic wait_grant();
        int k;
        for (k = 0; k < 200; k++) begin
            cyc();
            if (last_gnt != 2'b00) break;
        end
        if (k == 200) chk("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rsp();
        int k;
        got_rsp = 1'b0;
        for (k = 0; k < 200; k++) begin
            cyc();
            if (got_rsp) break;
        end
        if (k == 200) chk("rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rspv();
        int k;
        for (k = 0; k < 200 && !rsp_valid; k++) cyc();
        if (!rsp_valid) chk("rspv_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_start();
        int s = n_start;
        for (int k = 0; k < 20 && n_start == s; k++) cyc();
        chk("start_seen", 32'(n_start - s), 32'd1);
    endtask

    initial begin
        int s0, rv0;
        tbl[0] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[1] = '{1'b1, 1'b0, 32'd100,       32'd7,          32'd14,        32'd2};
        tbl[2] = '{1'b1, 1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5};
        tbl[3] = '{1'b0, 1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1};
        tbl[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF, 32'd1};
        tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF8};

        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_grant", 32'(req_grant), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin: both requesting on every arbitration until port 1 drops out.
        req_signed = 2'b00;
        req_a0 = 32'd100; req_b0 = 32'd3; req_a1 = 32'd200; req_b1 = 32'd7;
        req_valid = 2'b11;
        wait_grant(); chk("rr_first", 32'(last_gnt), 32'd1);
        req_a0 = 32'd301; req_b0 = 32'd10;
        wait_grant(); chk("rr_second", 32'(last_gnt), 32'd2);
        req_valid = 2'b01;
        wait_grant(); chk("rr_third", 32'(last_gnt), 32'd1);
        req_valid = 2'b00;
        for (int k = 0; k < 300 && sb.size() != 0; k++) cyc();
        chk("rr_drained", 32'(sb.size()), 32'd0);
        cyc();

        for (int i = 0; i < 6; i++) begin
            req_signed = {tbl[i].sgn, tbl[i].sgn};
            if (tbl[i].id) begin req_a1 = tbl[i].a; req_b1 = tbl[i].b; req_valid = 2'b10; end
            else           begin req_a0 = tbl[i].a; req_b0 = tbl[i].b; req_valid = 2'b01; end
            s0 = n_start;
            wait_grant();
            chk($sformatf("v%0d_grant", i), 32'(last_gnt), tbl[i].id ? 32'd2 : 32'd1);
            req_valid = 2'b00;
            wait_rsp();
            chk($sformatf("v%0d_q", i), last_q, tbl[i].q);
            chk($sformatf("v%0d_r", i), last_r, tbl[i].r);
            chk($sformatf("v%0d_id", i), 32'(last_id), 32'(tbl[i].id));
            chk($sformatf("v%0d_err", i), 32'(last_err), 32'd0);
            chk($sformatf("v%0d_lat", i), 32'(rsp_cyc - gnt_cyc), (tbl[i].b == 0) ? 32'd1 : 32'd35);
            chk($sformatf("v%0d_starts", i), 32'(n_start - s0), (tbl[i].b == 0) ? 32'd0 : 32'd1);
        end

        // Cancel in WAIT: drain the divider silently, then serve port 1.
        req_signed = 2'b00; req_a0 = 32'd1000; req_b0 = 32'd10; req_valid = 2'b01;
        wait_grant(); req_valid = 2'b00;
        wait_start();
        for (int k = 0; k < 9; k++) cyc();
        rv0 = n_rspv;
        cancel = 2'b01; cyc(); cancel = 2'b00;
        void'(sb.pop_back());
        for (int k = 0; k < 100 && div_busy; k++) begin
            chk("drain_busy", 32'(sched_busy), 32'd1);
            cyc();
        end
        chk("drain_last", 32'(sched_busy), 32'd1);
        cyc();
        chk("drain_idle", 32'(sched_busy), 32'd0);
        chk("drain_no_rsp", 32'(n_rspv - rv0), 32'd0);
        req_a1 = 32'd9; req_b1 = 32'd3; req_valid = 2'b10;
        wait_grant(); chk("post_cancel_grant", 32'(last_gnt), 32'd2);
        req_valid = 2'b00;
        wait_rsp();

        // Watchdog: stuck divider, response held under backpressure.
        stuck = 1'b1; exp_wdog = 1'b1;
        req_a0 = 32'd50; req_b0 = 32'd5; req_valid = 2'b01;
        wait_grant(); req_valid = 2'b00; exp_wdog = 1'b0; rsp_ready = 1'b0;
        wait_rspv();
        chk("wdog_lat", 32'(cyc_n - start_cyc), 32'd42);
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_err", 32'(rsp_err), 32'd1);
            chk("hold_q", rsp_q, 32'd0);
            chk("hold_r", rsp_r, 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        wait_rsp();
        stuck = 1'b0;
        for (int k = 0; k < 100 && div_busy; k++) cyc();

        // Same-cycle cancel blocks a grant; cancel in RESP only from the owner.
        req_a0 = 32'd8; req_b0 = 32'd2; req_valid = 2'b01; cancel = 2'b01;
        cyc(); chk("cancel_idle", 32'(last_gnt), 32'd0);
        req_a1 = 32'd20; req_b1 = 32'd4; req_valid = 2'b11;
        wait_grant(); chk("cancel_idle_other", 32'(last_gnt), 32'd2);
        req_valid = 2'b00; cancel = 2'b00; rsp_ready = 1'b0;
        wait_rspv();
        cancel = 2'b01; cyc();
        chk("nonowner_cancel", 32'(rsp_valid), 32'd1);
        cancel = 2'b10; cyc(); cancel = 2'b00;
        chk("resp_cancel_valid", 32'(rsp_valid), 32'd0);
        chk("resp_cancel_idle", 32'(sched_busy), 32'd0);
        void'(sb.pop_back());
        rsp_ready = 1'b1;

        // Reset mid-WAIT.
        req_signed = 2'b11; req_a0 = 32'd77; req_b0 = 32'd7; req_valid = 2'b01;
        wait_grant(); req_valid = 2'b00;
        wait_start();
        for (int k = 0; k < 5; k++) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(sched_busy), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_start", 32'(div_start), 32'd0);
        chk("mid_rst_div_a", div_a, 32'd0);
        chk("mid_rst_div_b", div_b, 32'd0);
        chk("mid_rst_signed", 32'(div_signed), 32'd0);
        chk("mid_rst_q", rsp_q, 32'd0);
        chk("mid_rst_r", rsp_r, 32'd0);
        chk("mid_rst_id_err", 32'({rsp_id, rsp_err}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_signed = 2'b00;
        req_a0 = 32'd40; req_b0 = 32'd6; req_a1 = 32'd41; req_b1 = 32'd5; req_valid = 2'b11;
        wait_grant(); chk("post_rst_ptr", 32'(last_gnt), 32'd1);
        req_valid = 2'b00;
        wait_rsp();
        chk("post_rst_q", last_q, 32'd6);

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
